// File: rtl/jk_cmd_seq.sv
// Command sequencer for a downstream JK flip-flop: queues {cmd,len} requests in a
// small FIFO, drives j/k for len+1 cycles each, and shadows the expected q to flag mismatches.
module jk_cmd_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd,
  input  logic [3:0]              cmd_len,
  output logic                    cmd_ready,
  output logic                    j,
  output logic                    k,
  input  logic                    q_fb,
  output logic                    q_model,
  output logic                    err,
  input  logic                    err_clr,
  output logic                    busy,
  output logic                    cmd_done,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 6;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rep_q, rep_d;
  logic          j_q, j_d;
  logic          k_q, k_d;
  logic          q_model_q, q_model_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);

  // Next-state: FIFO bookkeeping, drive sequencing and the q shadow model.
  always_comb begin
    push      = cmd_valid && (cnt_q != CW'(DEPTH));
    pop       = 1'b0;
    state_d   = state_q;
    rep_d     = rep_q;
    j_d       = j_q;
    k_d       = k_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head[5:4];
          rep_d      = head[3:0];
          state_d    = DRIVE;
        end else begin
          {j_d, k_d} = 2'b00;
        end
      end
      DRIVE: begin
        if (rep_q != 4'd0) begin
          rep_d = rep_q - 4'd1;
        end else if (!fifo_empty) begin
          // Back-to-back load keeps the drive contiguous.
          pop        = 1'b1;
          {j_d, k_d} = head[5:4];
          rep_d      = head[3:0];
        end else begin
          {j_d, k_d} = 2'b00;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    ready_d  = (cnt_d != CW'(DEPTH));
    busy_d   = (state_d == DRIVE);
    done_d   = (state_d == DRIVE) && (rep_d == 4'd0);

    unique case ({j_q, k_q})
      2'b01:   q_model_d = 1'b0;
      2'b10:   q_model_d = 1'b1;
      2'b11:   q_model_d = ~q_model_q;
      default: q_model_d = q_model_q;
    endcase

    // A mismatch in the same cycle beats a clear.
    if (q_fb != q_model_q) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      q_model_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      j_q       <= j_d;
      k_q       <= k_d;
      q_model_q <= q_model_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd, cmd_len};
    end
  end

  assign cmd_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign q_model   = q_model_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign cmd_done  = done_q;
  assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every cycle.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       q_fb;
  logic       q_model;
  logic       err;
  logic       err_clr = 1'b0;
  logic       busy;
  logic       cmd_done;
  logic [2:0] fifo_cnt;

  logic       q_ff = 1'b0;
  logic       inject = 1'b0;
  logic       chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  jk_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .q_model   (q_model),
    .err       (err),
    .err_clr   (err_clr),
    .busy      (busy),
    .cmd_done  (cmd_done),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Real JK flip-flop downstream of the DUT; inject forces a feedback mismatch.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end
  assign q_fb = q_ff ^ inject;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending commands and the remaining drive cycles.
  logic [5:0] mq[$];
  logic [1:0] m_jk = 2'b00;
  int         m_rem = 0;
  logic       m_q = 1'b0;
  logic       m_err = 1'b0;
  logic [5:0] m_e;
  logic       m_push;
  logic       m_nerr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_jk  = 2'b00;
      m_rem = 0;
      m_q   = 1'b0;
      m_err = 1'b0;
    end else begin
      m_nerr = (q_fb != m_q) ? 1'b1 : (err_clr ? 1'b0 : m_err);
      case (m_jk)
        2'b01:   m_q = 1'b0;
        2'b10:   m_q = 1'b1;
        2'b11:   m_q = ~m_q;
        default: m_q = m_q;
      endcase
      m_err  = m_nerr;
      m_push = cmd_valid && (mq.size() < DEPTH);
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if (mq.size() > 0) begin
        m_e   = mq.pop_front();
        m_jk  = m_e[5:4];
        m_rem = int'(m_e[3:0]) + 1;
      end else begin
        m_jk  = 2'b00;
        m_rem = 0;
      end
      if (m_push) mq.push_back({cmd, cmd_len});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_j",        int'(j),         int'(m_jk[1]));
      chk("m_k",        int'(k),         int'(m_jk[0]));
      chk("m_busy",     int'(busy),      int'(m_rem > 0));
      chk("m_cmd_done", int'(cmd_done),  int'(m_rem == 1));
      chk("m_fifo_cnt", int'(fifo_cnt),  mq.size());
      chk("m_cmd_ready",int'(cmd_ready), int'(mq.size() < DEPTH));
      chk("m_q_model",  int'(q_model),   int'(m_q));
      chk("m_err",      int'(err),       int'(m_err));
    end
  end

  task automatic push1(input logic [1:0] c, input logic [3:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [1:0] seq_jk   [8];
  logic       seq_done [8];
  logic [5:0] fill     [5];

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cnt",   int'(fifo_cnt),  0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_jk",    int'({j, k}),    0);
    @(negedge clk);

    // Single set command, pushed on the first edge after release.
    rst_n = 1'b1; cmd_valid = 1'b1; cmd = 2'b10; cmd_len = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_cnt", int'(fifo_cnt), 1);
    chk("t1_jk0", int'({j, k}),   0);
    @(negedge clk);
    chk("t1_jk",   int'({j, k}),    2);
    chk("t1_done", int'(cmd_done),  1);
    @(negedge clk);
    chk("t1_jk_after", int'({j, k}),   0);
    chk("t1_q",        int'(q_model),  1);
    chk("t1_err",      int'(err),      0);

    // Toggle for four cycles returns q to its start value.
    push1(2'b11, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_jk",   int'({j, k}),   3);
      chk("t2_done", int'(cmd_done), int'(i == 3));
    end
    @(negedge clk);
    chk("t2_jk_after", int'({j, k}),  0);
    chk("t2_q",        int'(q_model), 1);

    // Fill the FIFO behind a long hold command; the fifth request is dropped.
    fill[0] = 6'b10_0001; fill[1] = 6'b01_0000; fill[2] = 6'b11_0010;
    fill[3] = 6'b10_0000; fill[4] = 6'b11_1111;
    seq_jk   = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0};
    seq_done = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b00; cmd_len = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("t3_full_cnt",   int'(fifo_cnt),  4);
        chk("t3_full_ready", int'(cmd_ready), 0);
      end
      {cmd, cmd_len} = fill[i];
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t3_drop_cnt", int'(fifo_cnt), 4);
    for (int n = 0; n < 40 && cmd_done != 1'b1; n++) @(negedge clk);
    chk("t3_blocker_done", int'(cmd_done), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_seq_jk",   int'({j, k}),   int'(seq_jk[i]));
      chk("t3_seq_done", int'(cmd_done), int'(seq_done[i]));
    end
    chk("t3_err", int'(err), 0);

    // Sticky error, clear, and set-beats-clear.
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("t4_err_set", int'(err), 1);
    @(negedge clk);
    chk("t4_err_sticky", int'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    chk("t4_err_clr", int'(err), 0);
    inject = 1'b1;
    @(negedge clk);
    chk("t4_err_set_wins", int'(err), 1);
    inject = 1'b0;
    @(negedge clk);
    chk("t4_err_clr2", int'(err), 0);
    err_clr = 1'b0;

    // Reset in the second drive cycle of a long toggle with two entries queued.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b11; cmd_len = 4'd5;
    @(negedge clk);
    cmd = 2'b01; cmd_len = 4'd2;
    @(negedge clk);
    cmd = 2'b10; cmd_len = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_pre_cnt",  int'(fifo_cnt), 2);
    chk("t5_pre_jk",   int'({j, k}),   3);
    chk("t5_pre_busy", int'(busy),     1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_jk",    int'({j, k}),    0);
    chk("t5_rst_q",     int'(q_model),   0);
    chk("t5_rst_err",   int'(err),       0);
    chk("t5_rst_busy",  int'(busy),      0);
    chk("t5_rst_done",  int'(cmd_done),  0);
    chk("t5_rst_cnt",   int'(fifo_cnt),  0);
    chk("t5_rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_post_jk",  int'({j, k}),   0);
      chk("t5_post_cnt", int'(fifo_cnt), 0);
    end

    // Random traffic checked by the per-cycle model.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd       = 2'($urandom);
      cmd_len   = 4'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    repeat (40) @(negedge clk);
    chk("end_idle_cnt", int'(fifo_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
